// File: rtl/clm_inverter_pkg.sv
// ============================================================================
// Module  : clm_inverter_pkg
// Brief   : Shared CLM-domain types and constants for the GF(2^8) inverter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package clm_inverter_pkg;

  localparam int CLM_D = 2;
  localparam int INV_OPS = 13;
  localparam logic [8:0] AES_POLY = 9'h11B;

  typedef logic [7+CLM_D:0]          state_t;
  typedef logic [CLM_D-1:0]          red_poly_t;
  typedef logic [6+2*CLM_D:0][7:0]   mul_m_matrix_t;

  typedef enum logic [1:0] {
    INV_IDLE = 2'd0,
    INV_RUN  = 2'd1,
    INV_DONE = 2'd2
  } inv_state_e;

endpackage

`default_nettype wire

// File: rtl/clm_inverter_multiplier.sv
// ============================================================================
// Module  : multiplier
// Brief   : Combinational CLM multiplier: carry-less product, systematic
//           reduction through B_ext, then re-randomisation with r*P.
// Revision: 1.0
// ============================================================================
`default_nettype none

module multiplier
  import clm_inverter_pkg::*;
#(
  parameter int d = 2
) (
  input  logic [7+d:0]           p1,
  input  logic [7+d:0]           p2,
  input  logic [(7+2*d)*8-1:0]   B_ext,
  input  logic [d-1:0]           r,
  output logic [7+d:0]           prod
);

  localparam int W  = 8 + d;
  localparam int FW = 2 * W - 1;

  logic [FW-1:0] w_full;
  logic [7:0]    w_red;
  logic [W-1:0]  w_refresh;

  always_comb begin
    w_full = '0;
    for (int i = 0; i < W; i++) begin
      if (p2[i]) w_full = w_full ^ (FW'(p1) << i);
    end
  end

  // Row i of B_ext is x^(8+i) folded into the 8-bit systematic part.
  always_comb begin
    w_red = w_full[7:0];
    for (int i = 0; i < FW - 8; i++) begin
      if (w_full[8+i]) w_red = w_red ^ B_ext[i*8 +: 8];
    end
  end

  always_comb begin
    w_refresh = '0;
    for (int i = 0; i < d; i++) begin
      if (r[i]) w_refresh = w_refresh ^ (W'(AES_POLY) << i);
    end
  end

  assign prod = {{d{1'b0}}, w_red} ^ w_refresh;

endmodule

`default_nettype wire

// File: rtl/clm_inverter.sv
// ============================================================================
// Module  : clm_inverter
// Brief   : Sequential CLM-domain GF(2^8) inverter (x^254) using one shared
//           CLM multiplier. Option: CLM_INV_STALL_CNT_EN adds stall_cnt.
// Revision: 1.0
// ============================================================================
`default_nettype none

module clm_inverter
  import clm_inverter_pkg::*;
#(
  parameter int d = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7+d:0]           in_data,
  input  logic [(7+2*d)*8-1:0]   B_ext,
  input  logic                   rand_valid,
  output logic                   rand_ready,
  input  logic [d-1:0]           rand_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7+d:0]           out_data
`ifdef CLM_INV_STALL_CNT_EN
  ,
  output logic [15:0]            stall_cnt
`endif
);

  localparam logic [1:0] S_IDLE  = INV_IDLE;
  localparam logic [1:0] S_RUN   = INV_RUN;
  localparam logic [1:0] S_DONE  = INV_DONE;
  localparam logic [3:0] LAST_OP = 4'(INV_OPS - 1);

  logic [1:0]   r_state;
  logic [3:0]   r_op_cnt;
  logic [7+d:0] r_sq;
  logic [7+d:0] r_acc;
  logic [7+d:0] w_p1;
  logic [7+d:0] w_prod;

  // Op 0 and odd ops square; even ops fold the running square into acc.
  assign w_p1 = ((r_op_cnt == 4'd0) || r_op_cnt[0]) ? r_sq : r_acc;

  multiplier #(
    .d(d)
  ) u_mul (
    .p1   (w_p1),
    .p2   (r_sq),
    .B_ext(B_ext),
    .r    (rand_data),
    .prod (w_prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op_cnt <= '0;
      r_sq     <= '0;
      r_acc    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sq     <= in_data;
            r_acc    <= in_data;
            r_op_cnt <= '0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (rand_valid) begin
            r_op_cnt <= r_op_cnt + 4'd1;
            if (r_op_cnt == 4'd0) begin
              r_sq  <= w_prod;
              r_acc <= w_prod;
            end else if (r_op_cnt[0]) begin
              r_sq  <= w_prod;
            end else begin
              r_acc <= w_prod;
            end
            if (r_op_cnt == LAST_OP) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign rand_ready = (r_state == S_RUN);
  assign out_valid  = (r_state == S_DONE);
  assign out_data   = out_valid ? r_acc : '0;

`ifdef CLM_INV_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if ((r_state == S_IDLE) && in_valid) begin
      r_stall_cnt <= '0;
    end else if ((r_state == S_RUN) && !rand_valid && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_clm_inverter.sv
// ============================================================================
// Module  : tb_clm_inverter
// Brief   : Scoreboard bench for clm_inverter against a GF(2^8) inverse table.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_clm_inverter;
  import clm_inverter_pkg::*;

  localparam int D = CLM_D;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  state_t        in_data = '0;
  mul_m_matrix_t B_ext;
  logic          rand_valid = 1'b0;
  logic          rand_ready;
  red_poly_t     rand_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  state_t        out_data;
`ifdef CLM_INV_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0 = 0;
  int rand_hs = 0;
  int rv_mode = 0;
  int or_mode = 0;
  logic [7:0] expq[$];
  logic [7:0] inv_tab [256];
  logic [7:0] mon_exp;

  clm_inverter #(.d(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .B_ext     (B_ext),
    .rand_valid(rand_valid),
    .rand_ready(rand_ready),
    .rand_data (rand_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef CLM_INV_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] red_int(input int v);
    for (int b = 30; b >= 8; b--) begin
      if (v[b]) v = v ^ (32'h11B << (b - 8));
    end
    return v[7:0];
  endfunction

  function automatic logic [7:0] decode(input state_t v);
    return red_int(int'(v));
  endfunction

  function automatic state_t encode(input logic [7:0] x, input red_poly_t r);
    state_t v;
    state_t pp;
    v  = {{D{1'b0}}, x};
    pp = state_t'(9'h11B);
    for (int i = 0; i < D; i++) begin
      if (r[i]) v = v ^ (pp << i);
    end
    return v;
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1B;
      b  = b >> 1;
    end
    return p;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Refresh source: always valid, phase-locked toggle, or random.
  always @(posedge clk) begin
    #2;
    rand_data = red_poly_t'($urandom);
    case (rv_mode)
      0:       rand_valid = 1'b1;
      1:       rand_valid = (((cyc - t0) % 2) != 0);
      default: rand_valid = 1'($urandom_range(0, 1));
    endcase
  end

  always @(posedge clk) begin
    #1;
    if (or_mode == 0) out_ready = 1'b1;
    else if (or_mode == 1) out_ready = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (rand_valid && rand_ready) rand_hs++;
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got %0h expected none", out_data);
        end else begin
          mon_exp = expq.pop_front();
          check("result", 32'(decode(out_data)), 32'(mon_exp));
        end
      end
    end
  end

  task automatic send(input logic [7:0] x, input logic [7:0] e);
    bit ok;
    ok = 1'b0;
    in_data  = encode(x, red_poly_t'($urandom));
    in_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      t0 = cyc;
      expq.push_back(e);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_out(output int lat);
    lat = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = cyc - t0;
        break;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ((expq.size() == 0) && in_ready) break;
    end
    check("drain", 32'(expq.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    int   h0;
    state_t v0;

    for (int i = 0; i < 7 + 2 * D; i++) B_ext[i] = red_int(1 << (8 + i));
    for (int a = 0; a < 256; a++) begin
      inv_tab[a] = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gmul(8'(a), 8'(b)) == 8'h01) inv_tab[a] = 8'(b);
      end
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_rand_ready", 32'(rand_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Golden: inv(0x53) = 0xCA, 13 cycles, 13 refresh words
    h0 = rand_hs;
    send(8'h53, 8'hCA);
    wait_out(lat);
    check("golden_latency", 32'(lat), 32'd13);
    check("golden_rand_hs", 32'(rand_hs - h0), 32'd13);
`ifdef CLM_INV_STALL_CNT_EN
    check("golden_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    @(posedge clk);
    #1;

    // Identity and zero under random refresh streams
    rv_mode = 2;
    for (int i = 0; i < 100; i++) begin
      if (i % 2 == 0) send(8'h01, 8'h01);
      else send(8'h00, 8'h00);
    end
    drain();
    @(posedge clk);
    #1;

    // Refresh stalls on every other cycle
    rv_mode = 1;
    h0 = rand_hs;
    send(8'hC3, inv_tab[8'hC3]);
    wait_out(lat);
    check("stall_latency", 32'(lat), 32'd26);
    check("stall_rand_hs", 32'(rand_hs - h0), 32'd13);
`ifdef CLM_INV_STALL_CNT_EN
    check("stall_cnt", 32'(stall_cnt), 32'd13);
`endif
    @(posedge clk);
    #1;

    // Output backpressure
    rv_mode = 0;
    or_mode = 2;
    out_ready = 1'b0;
    send(8'h10, inv_tab[8'h10]);
    wait_out(lat);
    check("bp_latency", 32'(lat), 32'd13);
    v0 = out_data;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_hold", {20'd0, out_valid, in_ready, rand_ready, 1'b0, v0},
            {20'd0, 1'b1, 1'b0, 1'b0, 1'b0, out_data});
      check("bp_flags", {29'd0, out_valid, in_ready, rand_ready}, 32'b100);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_idle", {30'd0, in_ready, out_valid}, 32'b10);
    or_mode = 0;
    @(posedge clk);
    #1;

    // Reset in the middle of a run
    send(8'h37, 8'h00);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_flags", {29'd0, in_ready, out_valid, rand_ready}, 32'b100);
    expq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(8'h02, 8'h8D);
    wait_out(lat);
    check("midrst_latency", 32'(lat), 32'd13);
    @(posedge clk);
    #1;

    // Exhaustive sweep with random refresh and random backpressure
    rv_mode = 2;
    or_mode = 1;
    for (int v = 0; v < 256; v++) send(8'(v), inv_tab[v]);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
